hilo_mdu: RTL and testbench

- Multiply/divide unit that owns the architectural HI/LO registers.
- The EX-stage ALU reads `hi`/`lo` combinationally for MFHI/MFLO.
- Executes MULT/MULTU/DIV/DIVU/MTHI/MTLO issued from the same EX slot, plus MADD/MSUB when the optional feature is enabled.
- Multi-cycle operations hold `busy` so issue logic stalls dependent MFHI/MFLO and further MDU ops.

---
 rtl/hilo_mdu.sv | 215 +++++++++++++++++++++
 tb/tb_hilo_mdu.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/hilo_mdu.sv
// hilo_mdu: multiply/divide unit that owns the architectural HI/LO registers.
// Latency: MTHI/MTLO/no-op/div-by-zero done N+1; MULT/MULTU N+2; MADD/MSUB N+3; DIV/DIVU N+DIV_CYCLES+2.
// Backpressure: req_ready = !busy; flush drops a same-cycle request and aborts any in-flight op without commit.
// Optional build macro HILO_MDU_MACC_EN adds MADD/MSUB (ACC state + 64-bit accumulate adder).
module hilo_mdu #(
   parameter int DIV_CYCLES = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic [2:0]  req_op,
   input  logic [31:0] src0,
   input  logic [31:0] src1,
   input  logic        flush,
   output logic        req_ready,
   output logic        busy,
   output logic        done,
   output logic        div_zero,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int CW = $clog2(DIV_CYCLES);
   localparam logic [CW-1:0] LAST_ITER = CW'(DIV_CYCLES - 1);

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;
   localparam logic [2:0] OP_MADD  = 3'd6;
   localparam logic [2:0] OP_MSUB  = 3'd7;

   typedef enum logic [2:0] {S_IDLE, S_MUL, S_ACC, S_DIV, S_FIN} state_t;

   state_t          r_state, w_next;
   logic [31:0]     r_hi, r_lo;
   logic            r_done, r_dz;
   logic [2:0]      r_op;
   logic [31:0]     r_a, r_b;
   logic [31:0]     r_quo, r_rem, r_div;
   logic [CW-1:0]   r_cnt;
   logic            r_neg_q, r_neg_r;
`ifdef HILO_MDU_MACC_EN
   logic [63:0]     r_prod;
`endif

   logic            w_accept, w_src1_zero, w_is_div_signed;
   logic [31:0]     w_src0_mag, w_src1_mag;
   logic            w_sgn;
   logic [63:0]     w_a_ext, w_b_ext, w_prod;
   logic [32:0]     w_rem_sh, w_trial;
   logic            w_qbit;
   logic [31:0]     w_rem_nxt, w_quo_fix, w_rem_fix;
   logic            w_commit, w_done_nxt, w_dz_nxt;
   logic [63:0]     w_commit_val;

   assign busy      = (r_state != S_IDLE);
   assign req_ready = !busy;
   assign done      = r_done;
   assign div_zero  = r_dz;
   assign hi        = r_hi;
   assign lo        = r_lo;

   assign w_accept        = req_valid && req_ready && !flush;
   assign w_src1_zero     = (src1 == 32'd0);
   assign w_is_div_signed = (req_op == OP_DIV);
   // The divider works on magnitudes; signs are re-applied in FIN.
   assign w_src0_mag = (w_is_div_signed && src0[31]) ? -src0 : src0;
   assign w_src1_mag = (w_is_div_signed && src1[31]) ? -src1 : src1;

   // Sign- or zero-extend to 64 bits so one multiplier serves both signed and unsigned forms.
   assign w_sgn   = (r_op == OP_MULT) || (r_op == OP_MADD) || (r_op == OP_MSUB);
   assign w_a_ext = {{32{w_sgn & r_a[31]}}, r_a};
   assign w_b_ext = {{32{w_sgn & r_b[31]}}, r_b};
   assign w_prod  = w_a_ext * w_b_ext;

   // Restoring step: the 33rd bit of the trial difference is the borrow.
   assign w_rem_sh  = {r_rem, r_quo[31]};
   assign w_trial   = w_rem_sh - {1'b0, r_div};
   assign w_qbit    = !w_trial[32];
   assign w_rem_nxt = w_qbit ? w_trial[31:0] : w_rem_sh[31:0];
   assign w_quo_fix = r_neg_q ? -r_quo : r_quo;
   assign w_rem_fix = r_neg_r ? -r_rem : r_rem;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // Next-state, commit selection and done/div_zero pulse generation.
   always_comb begin
      w_next       = r_state;
      w_commit     = 1'b0;
      w_commit_val = 64'd0;
      w_done_nxt   = 1'b0;
      w_dz_nxt     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               case (req_op)
                  OP_MULT, OP_MULTU: w_next = S_MUL;
                  OP_DIV, OP_DIVU: begin
                     if (w_src1_zero) begin
                        w_done_nxt = 1'b1;
                        w_dz_nxt   = 1'b1;
                     end else begin
                        w_next = S_DIV;
                     end
                  end
`ifdef HILO_MDU_MACC_EN
                  OP_MADD, OP_MSUB: w_next = S_MUL;
`endif
                  default: w_done_nxt = 1'b1;
               endcase
            end
         end
         S_MUL: begin
            if (flush) begin
               w_next = S_IDLE;
            end
`ifdef HILO_MDU_MACC_EN
            else if (r_op == OP_MADD || r_op == OP_MSUB) begin
               w_next = S_ACC;
            end
`endif
            else begin
               w_commit     = 1'b1;
               w_commit_val = w_prod;
               w_next       = S_IDLE;
            end
         end
`ifdef HILO_MDU_MACC_EN
         S_ACC: begin
            if (flush) begin
               w_next = S_IDLE;
            end else begin
               w_commit     = 1'b1;
               w_commit_val = (r_op == OP_MSUB) ? ({r_hi, r_lo} - r_prod) : ({r_hi, r_lo} + r_prod);
               w_next       = S_IDLE;
            end
         end
`endif
         S_DIV: begin
            if (flush)                   w_next = S_IDLE;
            else if (r_cnt == LAST_ITER) w_next = S_FIN;
         end
         S_FIN: begin
            if (flush) begin
               w_next = S_IDLE;
            end else begin
               w_commit     = 1'b1;
               w_commit_val = {w_rem_fix, w_quo_fix};
               w_next       = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
      w_done_nxt = w_done_nxt | w_commit;
   end

   // HI/LO, operand capture, divider iteration and status pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_hi    <= '0;
         r_lo    <= '0;
         r_done  <= 1'b0;
         r_dz    <= 1'b0;
         r_op    <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_quo   <= '0;
         r_rem   <= '0;
         r_div   <= '0;
         r_cnt   <= '0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
`ifdef HILO_MDU_MACC_EN
         r_prod  <= '0;
`endif
      end else begin
         r_done <= w_done_nxt;
         r_dz   <= w_dz_nxt;
         if (w_commit) begin
            {r_hi, r_lo} <= w_commit_val;
         end else if (r_state == S_IDLE && w_accept && req_op == OP_MTHI) begin
            r_hi <= src0;
         end else if (r_state == S_IDLE && w_accept && req_op == OP_MTLO) begin
            r_lo <= src0;
         end
         if (r_state == S_IDLE && w_accept) begin
            r_op    <= req_op;
            r_a     <= src0;
            r_b     <= src1;
            r_quo   <= w_src0_mag;
            r_div   <= w_src1_mag;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_neg_q <= w_is_div_signed && (src0[31] ^ src1[31]);
            r_neg_r <= w_is_div_signed && src0[31];
         end
         if (r_state == S_DIV) begin
            r_rem <= w_rem_nxt;
            r_quo <= {r_quo[30:0], w_qbit};
            r_cnt <= r_cnt + CW'(1);
         end
`ifdef HILO_MDU_MACC_EN
         if (r_state == S_MUL) r_prod <= w_prod;
`endif
      end
   end

endmodule

// File: tb/tb_hilo_mdu.sv
// tb_hilo_mdu: directed bench for hilo_mdu with a scoreboard of expected HI/LO/div_zero/latency.
// Inputs driven and outputs sampled on the falling clock edge.
// Expected results come from plain 64-bit integer arithmetic in the bench.
module tb_hilo_mdu;

   logic        clk = 1'b0;
   logic        reset, req_valid, flush;
   logic [2:0]  req_op;
   logic [31:0] src0, src1;
   logic        req_ready, busy, done, div_zero;
   logic [31:0] hi, lo;

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
      int          lat;
   } exp_t;
   exp_t scb[$];

   hilo_mdu #(.DIV_CYCLES(32)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
      .src0(src0), .src1(src1), .flush(flush), .req_ready(req_ready),
      .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   // Reference model: update the bench's HI/LO copy and queue the expected outcome.
   task automatic push_expect(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      longint sa, sbv, p, q, r;
      logic [63:0] u, acc;
      e.hi = m_hi; e.lo = m_lo; e.dz = 1'b0; e.lat = 1;
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      case (op)
         3'd0: begin p = sa * sbv; e.hi = p[63:32]; e.lo = p[31:0]; e.lat = 2; end
         3'd1: begin u = {32'h0, a} * {32'h0, b}; e.hi = u[63:32]; e.lo = u[31:0]; e.lat = 2; end
         3'd2: begin
            if (b == 32'd0) e.dz = 1'b1;
            else begin q = sa / sbv; r = sa % sbv; e.lo = q[31:0]; e.hi = r[31:0]; e.lat = 34; end
         end
         3'd3: begin
            if (b == 32'd0) e.dz = 1'b1;
            else begin e.lo = a / b; e.hi = a % b; e.lat = 34; end
         end
         3'd4: e.hi = a;
         3'd5: e.lo = a;
         default: begin
`ifdef HILO_MDU_MACC_EN
            p = sa * sbv;
            acc = (op == 3'd7) ? ({m_hi, m_lo} - p) : ({m_hi, m_lo} + p);
            e.hi = acc[63:32]; e.lo = acc[31:0]; e.lat = 3;
`endif
         end
      endcase
      m_hi = e.hi; m_lo = e.lo;
      scb.push_back(e);
   endtask

   // Issue one request, wait for done, then pop the scoreboard and compare.
   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      int lat, nbusy;
      logic stable;
      logic [31:0] h0, l0;
      chk({tag, ".ready"}, {63'd0, req_ready}, 64'd1);
      push_expect(op, a, b);
      h0 = hi; l0 = lo;
      req_valid = 1'b1; req_op = op; src0 = a; src1 = b;
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1; nbusy = 0; stable = 1'b1;
      while (!done && lat < 100) begin
         if (busy) nbusy++;
         if (hi !== h0 || lo !== l0) stable = 1'b0;
         @(negedge clk);
         lat++;
      end
      e = scb.pop_front();
      chk({tag, ".lat"},   64'(lat), 64'(e.lat));
      chk({tag, ".busy"},  64'(nbusy), 64'(e.lat - 1));
      chk({tag, ".hold"},  {63'd0, stable}, 64'd1);
      chk({tag, ".hi"},    {32'd0, hi}, {32'd0, e.hi});
      chk({tag, ".lo"},    {32'd0, lo}, {32'd0, e.lo});
      chk({tag, ".dz"},    {63'd0, div_zero}, {63'd0, e.dz});
      chk({tag, ".bsy0"},  {63'd0, busy}, 64'd0);
      @(negedge clk);
      chk({tag, ".pulse"}, {62'd0, done, div_zero}, 64'd0);
   endtask

   initial begin
      logic [31:0] h0, l0;
      int nd, nb;
      reset = 1'b1; req_valid = 1'b1; req_op = 3'd4; src0 = 32'hDEADBEEF; src1 = 32'd0; flush = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst.hi",   {32'd0, hi}, 64'd0);
      chk("rst.lo",   {32'd0, lo}, 64'd0);
      chk("rst.busy", {63'd0, busy}, 64'd0);
      chk("rst.done", {62'd0, done, div_zero}, 64'd0);
      reset = 1'b0; req_valid = 1'b0;
      @(negedge clk);
      chk("rst.after", {hi, lo}, 64'd0);

      run_op("mult", 3'd0, 32'hFFFFFFFD, 32'd5);
      chk("mult.const", {hi, lo}, 64'hFFFFFFFF_FFFFFFF1);
      run_op("multu", 3'd1, 32'hFFFFFFFD, 32'd5);
      chk("multu.const", {hi, lo}, 64'h00000004_FFFFFFF1);
      run_op("mult_big", 3'd0, 32'h80000000, 32'h80000000);
      run_op("divu", 3'd3, 32'd100, 32'd7);
      chk("divu.const", {hi, lo}, {32'd2, 32'd14});
      run_op("div", 3'd2, 32'hFFFFFFF9, 32'd2);
      chk("div.const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
      run_op("div_negb", 3'd2, 32'd7, 32'hFFFFFFFE);
      run_op("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF);
      chk("div_ovf.const", {hi, lo}, 64'h00000000_80000000);
      run_op("divu_max", 3'd3, 32'hFFFFFFFF, 32'h00000003);

      run_op("mthi", 3'd4, 32'h11, 32'd0);
      run_op("mtlo", 3'd5, 32'h22, 32'd0);
      run_op("div0", 3'd2, 32'h1234, 32'd0);
      chk("div0.const", {hi, lo}, {32'h11, 32'h22});

      // Divide aborted by flush in cycle N+10.
      h0 = hi; l0 = lo;
      req_valid = 1'b1; req_op = 3'd3; src0 = 32'd1000; src1 = 32'd3;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (9) @(negedge clk);
      chk("fl_div.busy", {63'd0, busy}, 64'd1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("fl_div.idle", {62'd0, busy, !req_ready}, 64'd0);
      nd = 0;
      for (int i = 0; i < 40; i++) begin
         if (done) nd++;
         @(negedge clk);
      end
      chk("fl_div.nodone", 64'(nd), 64'd0);
      chk("fl_div.hilo", {hi, lo}, {h0, l0});
      run_op("mtlo_fl", 3'd5, 32'hABCD, 32'd0);
      chk("mtlo_fl.const", {hi, lo}, {32'h11, 32'hABCD});

      // Flush in the MUL commit cycle wins.
      h0 = hi; l0 = lo;
      req_valid = 1'b1; req_op = 3'd0; src0 = 32'd7; src1 = 32'd9;
      @(negedge clk);
      req_valid = 1'b0; flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      nd = 0; nb = 0;
      for (int i = 0; i < 5; i++) begin
         if (done) nd++;
         if (busy) nb++;
         @(negedge clk);
      end
      chk("fl_mul.nodone", 64'(nd + nb), 64'd0);
      chk("fl_mul.hilo", {hi, lo}, {h0, l0});

      // Flush in the request cycle drops the request.
      req_valid = 1'b1; req_op = 3'd4; src0 = 32'h5555; flush = 1'b1;
      @(negedge clk);
      req_valid = 1'b0; flush = 1'b0;
      chk("fl_req.state", {61'd0, busy, done, div_zero}, 64'd0);
      chk("fl_req.hilo", {hi, lo}, {h0, l0});

      // MADD/MSUB: accumulate when built in, no-op otherwise.
      run_op("mthi0", 3'd4, 32'd0, 32'd0);
      run_op("mtlo1", 3'd5, 32'd1, 32'd0);
      run_op("madd", 3'd6, 32'd3, 32'hFFFFFFFE);
`ifdef HILO_MDU_MACC_EN
      chk("madd.const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFB);
`else
      chk("madd.const", {hi, lo}, 64'h00000000_00000001);
`endif
      run_op("msub", 3'd7, 32'hFFFFFFFF, 32'd4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
